// File: rtl/tlul_to_reg_if.sv
// Bundles the TL-UL A/D channels and the reg_interface request/response of the bridge.
// The slave modport is the bridge's view; master is the environment around it.
interface tlul_to_reg_if #(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int SourceW = 8
);
   logic               tl_a_valid;
   logic               tl_a_ready;
   logic [2:0]         tl_a_opcode;
   logic [1:0]         tl_a_size;
   logic [SourceW-1:0] tl_a_source;
   logic [AW-1:0]      tl_a_address;
   logic [DW/8-1:0]    tl_a_mask;
   logic [DW-1:0]      tl_a_data;

   logic               tl_d_valid;
   logic               tl_d_ready;
   logic [2:0]         tl_d_opcode;
   logic [1:0]         tl_d_size;
   logic [SourceW-1:0] tl_d_source;
   logic [DW-1:0]      tl_d_data;
   logic               tl_d_error;

   logic               reg_valid;
   logic               reg_write;
   logic [AW-1:0]      reg_addr;
   logic [DW-1:0]      reg_wdata;
   logic [DW/8-1:0]    reg_wstrb;
   logic               reg_ready;
   logic [DW-1:0]      reg_rdata;
   logic               reg_error;

   modport slave (
      input  tl_a_valid, tl_a_opcode, tl_a_size, tl_a_source, tl_a_address, tl_a_mask, tl_a_data,
      output tl_a_ready,
      output tl_d_valid, tl_d_opcode, tl_d_size, tl_d_source, tl_d_data, tl_d_error,
      input  tl_d_ready,
      output reg_valid, reg_write, reg_addr, reg_wdata, reg_wstrb,
      input  reg_ready, reg_rdata, reg_error
   );

   modport master (
      output tl_a_valid, tl_a_opcode, tl_a_size, tl_a_source, tl_a_address, tl_a_mask, tl_a_data,
      input  tl_a_ready,
      input  tl_d_valid, tl_d_opcode, tl_d_size, tl_d_source, tl_d_data, tl_d_error,
      output tl_d_ready,
      input  reg_valid, reg_write, reg_addr, reg_wdata, reg_wstrb,
      output reg_ready, reg_rdata, reg_error
   );
endinterface

// File: rtl/tlul_to_reg.sv
// TL-UL device-side bridge: replays one A-channel transaction at a time as a
// reg_interface access and returns the D-channel response; all outputs come from registers.
module tlul_to_reg #(
   parameter int AW            = 32,
   parameter int DW            = 32,
   parameter int SourceW       = 8,
   parameter int TimeoutCycles = 0
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   tlul_to_reg_if.slave     bus_io
);

   localparam int MW      = DW / 8;
   localparam int OffW    = (MW > 1) ? $clog2(MW) : 1;
   localparam int MaxSize = $clog2(MW);
   localparam int CntW    = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;

   localparam logic [2:0] OpPutFull    = 3'd0;
   localparam logic [2:0] OpPutPartial = 3'd1;
   localparam logic [2:0] OpGet        = 3'd4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RSP  = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic [2:0]         op_q, op_d;
   logic [1:0]         size_q, size_d;
   logic [SourceW-1:0] source_q, source_d;
   logic [AW-1:0]      addr_q, addr_d;
   logic [MW-1:0]      mask_q, mask_d;
   logic [DW-1:0]      wdata_q, wdata_d;
   logic [DW-1:0]      rdata_q, rdata_d;
   logic               err_q, err_d;
   logic [CntW-1:0]    cnt_q, cnt_d;
   logic               timeout_hit;
   logic               a_legal;

   // Only the in-word byte offset of the address matters for alignment and lane coverage.
   function automatic logic legal_f(input logic [2:0]      op,
                                    input logic [1:0]      size,
                                    input logic [OffW-1:0] off_addr,
                                    input logic [MW-1:0]   mask);
      logic ok;
      int   off;
      int   nbytes;
      ok     = (op == OpPutFull) || (op == OpPutPartial) || (op == OpGet);
      nbytes = 1 << size;
      off    = int'(off_addr);
      if (int'(size) > MaxSize) ok = 1'b0;
      if ((off & (nbytes - 1)) != 0) ok = 1'b0;
      if (op == OpPutFull) begin
         for (int i = 0; i < MW; i++) begin
            if ((i >= off) && (i < off + nbytes) && !mask[i]) ok = 1'b0;
         end
      end
      return ok;
   endfunction

   assign a_legal = legal_f(bus_io.tl_a_opcode, bus_io.tl_a_size,
                            bus_io.tl_a_address[OffW-1:0], bus_io.tl_a_mask);

   // Expiry is the last REQ cycle still allowed to wait; a ready in that cycle still wins.
   assign timeout_hit = (TimeoutCycles > 0) && (cnt_q == CntW'(TimeoutCycles - 1));

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      size_d   = size_q;
      source_d = source_q;
      addr_d   = addr_q;
      mask_d   = mask_q;
      wdata_d  = wdata_q;
      rdata_d  = rdata_q;
      err_d    = err_q;
      cnt_d    = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (bus_io.tl_a_valid) begin
               op_d     = bus_io.tl_a_opcode;
               size_d   = bus_io.tl_a_size;
               source_d = bus_io.tl_a_source;
               addr_d   = bus_io.tl_a_address;
               mask_d   = bus_io.tl_a_mask;
               wdata_d  = bus_io.tl_a_data;
               rdata_d  = '0;
               cnt_d    = '0;
               if (a_legal) begin
                  err_d   = 1'b0;
                  state_d = REQ;
               end else begin
                  err_d   = 1'b1;
                  state_d = RSP;
               end
            end
         end
         REQ: begin
            if (bus_io.reg_ready) begin
               rdata_d = (op_q == OpGet) ? bus_io.reg_rdata : '0;
               err_d   = bus_io.reg_error;
               state_d = RSP;
            end else if (timeout_hit) begin
               rdata_d = '0;
               err_d   = 1'b1;
               state_d = RSP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RSP: begin
            if (bus_io.tl_d_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= IDLE;
         op_q     <= '0;
         size_q   <= '0;
         source_q <= '0;
         addr_q   <= '0;
         mask_q   <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
         err_q    <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         size_q   <= size_d;
         source_q <= source_d;
         addr_q   <= addr_d;
         mask_q   <= mask_d;
         wdata_q  <= wdata_d;
         rdata_q  <= rdata_d;
         err_q    <= err_d;
         cnt_q    <= cnt_d;
      end
   end

   assign bus_io.tl_a_ready  = (state_q == IDLE);

   assign bus_io.reg_valid   = (state_q == REQ);
   assign bus_io.reg_write   = (state_q == REQ) && (op_q != OpGet);
   assign bus_io.reg_addr    = addr_q;
   assign bus_io.reg_wdata   = wdata_q;
   assign bus_io.reg_wstrb   = bus_io.reg_write ? mask_q : '0;

   assign bus_io.tl_d_valid  = (state_q == RSP);
   assign bus_io.tl_d_opcode = {2'b00, (op_q == OpGet)};
   assign bus_io.tl_d_size   = size_q;
   assign bus_io.tl_d_source = source_q;
   assign bus_io.tl_d_data   = rdata_q;
   assign bus_io.tl_d_error  = err_q;

endmodule

// File: tb/tb_tlul_to_reg.sv
// Directed and randomized transactions against a transaction-level model of the bridge.
module tb_tlul_to_reg;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int SW = 8;
   localparam int TO = 8;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   tlul_to_reg_if #(.AW(AW), .DW(DW), .SourceW(SW)) bus ();

   tlul_to_reg #(.AW(AW), .DW(DW), .SourceW(SW), .TimeoutCycles(TO)) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus_io (bus)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Legality written directly from the TL-UL rules for a 4-byte bus.
   function automatic bit legal_m(input logic [2:0] op, input logic [1:0] size,
                                  input logic [31:0] addr, input logic [3:0] mask);
      int n;
      int off;
      if (!(op == 3'd0 || op == 3'd1 || op == 3'd4)) return 1'b0;
      if (size > 2'd2) return 1'b0;
      n   = 1 << size;
      off = int'(addr % 4);
      if ((addr % n) != 0) return 1'b0;
      if (op == 3'd0) begin
         for (int b = off; b < off + n; b++) if (!mask[b]) return 1'b0;
      end
      return 1'b1;
   endfunction

   task automatic drive_a(input logic [2:0] op, input logic [1:0] size, input logic [7:0] src,
                          input logic [31:0] addr, input logic [3:0] mask, input logic [31:0] data);
      bus.tl_a_valid   = 1'b1;
      bus.tl_a_opcode  = op;
      bus.tl_a_size    = size;
      bus.tl_a_source  = src;
      bus.tl_a_address = addr;
      bus.tl_a_mask    = mask;
      bus.tl_a_data    = data;
   endtask

   task automatic scramble_a();
      bus.tl_a_opcode  = 3'($urandom);
      bus.tl_a_size    = 2'($urandom);
      bus.tl_a_source  = 8'($urandom);
      bus.tl_a_address = $urandom;
      bus.tl_a_mask    = 4'($urandom);
      bus.tl_a_data    = $urandom;
   endtask

   // rwait: REQ cycles with reg_ready low before ready (>= TO means never). dwait: same for d_ready.
   task automatic do_txn(input string nm, input logic [2:0] op, input logic [1:0] size,
                         input logic [7:0] src, input logic [31:0] addr, input logic [3:0] mask,
                         input logic [31:0] data, input int rwait, input logic [31:0] rdata,
                         input logic rerr, input int dwait, input bit hold_a);
      bit          legal;
      bit          tmo;
      bit          done;
      bit          dhs;
      logic [31:0] exp_d;
      logic        exp_e;
      int          req_n, rsp_n, low_n, exp_req;
      legal   = legal_m(op, size, addr, mask);
      tmo     = legal && (rwait >= TO);
      exp_req = !legal ? 0 : (tmo ? TO : rwait + 1);
      if (!legal || tmo) begin
         exp_d = 32'h0;
         exp_e = 1'b1;
      end else begin
         exp_d = (op == 3'd4) ? rdata : 32'h0;
         exp_e = rerr;
      end
      @(negedge clk);
      check({nm, ".a_ready_idle"}, bus.tl_a_ready, 1);
      drive_a(op, size, src, addr, mask, data);
      @(posedge clk);
      @(negedge clk);
      bus.tl_a_valid = hold_a;
      scramble_a();
      req_n = 0;
      rsp_n = 0;
      low_n = 0;
      done  = 1'b0;
      for (int c = 0; c < 64 && !done; c++) begin
         dhs = 1'b0;
         if (!bus.tl_a_ready) low_n++;
         if (bus.reg_valid) begin
            check({nm, ".reg_write"}, bus.reg_write, (op != 3'd4));
            check({nm, ".reg_addr"},  bus.reg_addr, addr);
            check({nm, ".reg_wdata"}, bus.reg_wdata, data);
            check({nm, ".reg_wstrb"}, bus.reg_wstrb, (op == 3'd4) ? 4'h0 : mask);
            bus.reg_ready = (req_n == rwait);
            bus.reg_rdata = bus.reg_ready ? rdata : $urandom;
            bus.reg_error = bus.reg_ready ? rerr : 1'($urandom);
            req_n++;
         end else begin
            bus.reg_ready = 1'($urandom);
            bus.reg_rdata = $urandom;
            bus.reg_error = 1'($urandom);
         end
         if (bus.tl_d_valid) begin
            check({nm, ".d_opcode"}, bus.tl_d_opcode, {2'b00, (op == 3'd4)});
            check({nm, ".d_size"},   bus.tl_d_size, size);
            check({nm, ".d_source"}, bus.tl_d_source, src);
            check({nm, ".d_data"},   bus.tl_d_data, exp_d);
            check({nm, ".d_error"},  bus.tl_d_error, exp_e);
            bus.tl_d_ready = (rsp_n == dwait);
            dhs = bus.tl_d_ready;
            rsp_n++;
         end else begin
            bus.tl_d_ready = 1'($urandom);
         end
         @(posedge clk);
         @(negedge clk);
         done = dhs;
      end
      bus.tl_a_valid = 1'b0;
      bus.reg_ready  = 1'b0;
      bus.tl_d_ready = 1'b0;
      check({nm, ".completed"}, done, 1);
      check({nm, ".req_cycles"}, req_n, exp_req);
      check({nm, ".rsp_cycles"}, rsp_n, dwait + 1);
      check({nm, ".a_ready_low"}, low_n, exp_req + dwait + 1);
      check({nm, ".a_ready_after"}, bus.tl_a_ready, 1);
      check({nm, ".d_valid_after"}, bus.tl_d_valid, 0);
      check({nm, ".reg_valid_after"}, bus.reg_valid, 0);
   endtask

   task automatic check_reset_outputs(input string nm);
      check({nm, ".a_ready"},   bus.tl_a_ready, 1);
      check({nm, ".reg_valid"}, bus.reg_valid, 0);
      check({nm, ".reg_write"}, bus.reg_write, 0);
      check({nm, ".reg_addr"},  bus.reg_addr, 0);
      check({nm, ".reg_wdata"}, bus.reg_wdata, 0);
      check({nm, ".reg_wstrb"}, bus.reg_wstrb, 0);
      check({nm, ".d_valid"},   bus.tl_d_valid, 0);
      check({nm, ".d_opcode"},  bus.tl_d_opcode, 0);
      check({nm, ".d_source"},  bus.tl_d_source, 0);
      check({nm, ".d_data"},    bus.tl_d_data, 0);
      check({nm, ".d_error"},   bus.tl_d_error, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [2:0]  r_op;
      logic [1:0]  r_size;
      logic [31:0] r_addr;
      logic [3:0]  r_mask;
      int          off;

      rst_n          = 1'b0;
      bus.tl_a_valid = 1'b0;
      bus.tl_d_ready = 1'b0;
      bus.reg_ready  = 1'b0;
      bus.reg_rdata  = 32'h0;
      bus.reg_error  = 1'b0;
      scramble_a();
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      rst_n = 1'b1;

      do_txn("get_basic", 3'd4, 2'd2, 8'h05, 32'h10, 4'hF, 32'h0, 0, 32'hDEADBEEF, 1'b0, 1, 1'b0);
      do_txn("put_partial", 3'd1, 2'd2, 8'h11, 32'h8, 4'b0110, 32'h12345678, 4, 32'hCAFEF00D, 1'b0, 0, 1'b0);
      do_txn("ill_opcode", 3'd2, 2'd2, 8'h21, 32'h0, 4'hF, 32'h1, 0, 32'h0, 1'b0, 0, 1'b0);
      do_txn("ill_align", 3'd4, 2'd2, 8'h22, 32'h2, 4'hF, 32'h2, 0, 32'h0, 1'b0, 0, 1'b0);
      do_txn("ill_fullmask", 3'd0, 2'd2, 8'h23, 32'h0, 4'b0111, 32'h3, 0, 32'h0, 1'b0, 0, 1'b0);
      do_txn("d_stall", 3'd4, 2'd2, 8'h30, 32'h24, 4'hF, 32'h0, 1, 32'h600DD00D, 1'b1, 6, 1'b1);
      do_txn("timeout", 3'd4, 2'd2, 8'h40, 32'h40, 4'hF, 32'h0, 100, 32'hBADBAD00, 1'b0, 0, 1'b0);
      do_txn("late_ready", 3'd4, 2'd2, 8'h41, 32'h44, 4'hF, 32'h0, TO - 1, 32'h87654321, 1'b0, 0, 1'b0);
      do_txn("put_full_b", 3'd0, 2'd0, 8'h42, 32'h3, 4'b1000, 32'hAB000000, 2, 32'h0, 1'b1, 1, 1'b0);

      // Reset while a reg request is outstanding.
      @(negedge clk);
      drive_a(3'd4, 2'd2, 8'h50, 32'h50, 4'hF, 32'h0);
      @(posedge clk);
      @(negedge clk);
      bus.tl_a_valid = 1'b0;
      bus.reg_ready  = 1'b0;
      check("rst_req.pre_reg_valid", bus.reg_valid, 1);
      #2 rst_n = 1'b0;
      #1 check_reset_outputs("rst_req");
      @(negedge clk);
      rst_n = 1'b1;

      // Reset while the D response is waiting.
      @(negedge clk);
      drive_a(3'd4, 2'd2, 8'h51, 32'h54, 4'hF, 32'h0);
      @(posedge clk);
      @(negedge clk);
      bus.tl_a_valid = 1'b0;
      bus.reg_ready  = 1'b1;
      bus.reg_rdata  = 32'h5A5A5A5A;
      bus.reg_error  = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.reg_ready = 1'b0;
      check("rst_rsp.pre_d_valid", bus.tl_d_valid, 1);
      #2 rst_n = 1'b0;
      #1 check_reset_outputs("rst_rsp");
      @(negedge clk);
      rst_n = 1'b1;

      do_txn("get_after_rst", 3'd4, 2'd2, 8'h52, 32'h58, 4'hF, 32'h0, 0, 32'h13579BDF, 1'b0, 0, 1'b0);

      for (int k = 0; k < 40; k++) begin
         case ($urandom_range(0, 7))
            0, 1:    r_op = 3'd4;
            2, 3:    r_op = 3'd0;
            4, 5:    r_op = 3'd1;
            default: r_op = 3'($urandom_range(2, 7));
         endcase
         r_size = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
         r_addr = ($urandom & 32'hFFFF_FFFC) | 32'($urandom_range(0, 3));
         if ($urandom_range(0, 2) != 0 && r_size != 2'd3) begin
            r_addr = r_addr & ~((32'd1 << r_size) - 32'd1);
         end
         off    = int'(r_addr % 4);
         r_mask = 4'($urandom);
         if ($urandom_range(0, 1) == 1 && r_size != 2'd3) begin
            r_mask = 4'(((1 << (1 << r_size)) - 1) << off);
         end
         do_txn("rnd", r_op, r_size, 8'($urandom), r_addr, r_mask, $urandom,
                $urandom_range(0, 10), $urandom, 1'($urandom_range(0, 3) == 0),
                $urandom_range(0, 3), 1'($urandom));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
